// File: rtl/player_controller.sv
// Tile-grid player movement and bomb request controller: paced movement ticks,
// map lookup handshake before each step, and edge-triggered bomb requests with cooldown.
module player_controller #(
  parameter int GRID_W        = 15,
  parameter int GRID_H        = 11,
  parameter int START_X       = 1,
  parameter int START_Y       = 1,
  parameter int STEP_CYCLES   = 5000000,
  parameter int BOMB_COOLDOWN = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       x_moving,
  input  logic       xdir,
  input  logic       y_moving,
  input  logic       ydir,
  input  logic       bomb,
  input  logic       alive,
  output logic       query_req,
  output logic [3:0] query_x,
  output logic [3:0] query_y,
  input  logic       query_ack,
  input  logic       query_blocked,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       moved,
  output logic       bomb_req
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam int CW = $clog2(BOMB_COOLDOWN + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(BOMB_COOLDOWN - 1);
  localparam logic [4:0]    GW        = 5'(GRID_W);
  localparam logic [4:0]    GH        = 5'(GRID_H);

  typedef enum logic [1:0] {IDLE, QUERY, COMMIT} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [3:0]    query_x_q, query_x_d, query_y_q, query_y_d;
  logic          query_req_q, query_req_d;
  logic          abort_q, abort_d;
  logic          bomb_prev_q, bomb_prev_d;
  logic          bomb_req_q, bomb_req_d;
  logic [CW-1:0] cool_q, cool_d;

  logic       tick;
  logic [4:0] tgt_x, tgt_y;
  logic       tgt_ok;
  logic       fire;

  assign tick = (step_q == STEP_LAST);

  // Targets are computed one bit wider so stepping past the right/bottom edge is detectable.
  always_comb begin
    tgt_x  = {1'b0, pos_x_q};
    tgt_y  = {1'b0, pos_y_q};
    tgt_ok = 1'b0;
    if (x_moving) begin
      if (xdir) begin
        tgt_x  = {1'b0, pos_x_q} + 5'd1;
        tgt_ok = (tgt_x < GW);
      end else begin
        tgt_x  = {1'b0, pos_x_q} - 5'd1;
        tgt_ok = (pos_x_q != 4'd0);
      end
    end else if (y_moving) begin
      if (ydir) begin
        tgt_y  = {1'b0, pos_y_q} + 5'd1;
        tgt_ok = (tgt_y < GH);
      end else begin
        tgt_y  = {1'b0, pos_y_q} - 5'd1;
        tgt_ok = (pos_y_q != 4'd0);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = tick ? '0 : step_q + SW'(1);
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    query_x_d   = query_x_q;
    query_y_d   = query_y_q;
    query_req_d = query_req_q;
    abort_d     = abort_q;
    case (state_q)
      IDLE: begin
        if (tick && alive && tgt_ok) begin
          state_d     = QUERY;
          query_req_d = 1'b1;
          query_x_d   = tgt_x[3:0];
          query_y_d   = tgt_y[3:0];
          abort_d     = 1'b0;
        end
      end
      QUERY: begin
        // A death at any point during the lookup cancels the move once the ack arrives.
        if (!alive) abort_d = 1'b1;
        if (query_ack) begin
          query_req_d = 1'b0;
          if (!query_blocked && alive && !abort_q) state_d = COMMIT;
          else                                    state_d = IDLE;
        end
      end
      COMMIT: begin
        pos_x_d = query_x_q;
        pos_y_d = query_y_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bomb_prev_d = bomb;
    fire        = bomb && !bomb_prev_q && alive && (cool_q == '0);
    bomb_req_d  = fire;
    if (fire)              cool_d = COOL_LOAD;
    else if (cool_q != '0) cool_d = cool_q - CW'(1);
    else                   cool_d = cool_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      pos_x_q     <= 4'(START_X);
      pos_y_q     <= 4'(START_Y);
      query_x_q   <= '0;
      query_y_q   <= '0;
      query_req_q <= 1'b0;
      abort_q     <= 1'b0;
      bomb_prev_q <= 1'b0;
      bomb_req_q  <= 1'b0;
      cool_q      <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      query_x_q   <= query_x_d;
      query_y_q   <= query_y_d;
      query_req_q <= query_req_d;
      abort_q     <= abort_d;
      bomb_prev_q <= bomb_prev_d;
      bomb_req_q  <= bomb_req_d;
      cool_q      <= cool_d;
    end
  end

  // pos only updates at the end of COMMIT, so a coincident bomb_req sees the pre-move tile.
  assign moved     = (state_q == COMMIT);
  assign query_req = query_req_q;
  assign query_x   = query_x_q;
  assign query_y   = query_y_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign bomb_req  = bomb_req_q;

endmodule

// File: tb/tb_player_controller.sv
// Directed self-checking bench for player_controller (STEP_CYCLES=8, BOMB_COOLDOWN=20).
module tb_player_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       x_moving, xdir, y_moving, ydir, bomb, alive;
  logic       query_req, query_ack, query_blocked;
  logic [3:0] query_x, query_y, pos_x, pos_y;
  logic       moved, bomb_req;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned moved_cnt = 0;

  player_controller #(
    .GRID_W(15), .GRID_H(11), .START_X(1), .START_Y(1),
    .STEP_CYCLES(8), .BOMB_COOLDOWN(20)
  ) dut (
    .clock(clock), .reset(reset),
    .x_moving(x_moving), .xdir(xdir), .y_moving(y_moving), .ydir(ydir),
    .bomb(bomb), .alive(alive),
    .query_req(query_req), .query_x(query_x), .query_y(query_y),
    .query_ack(query_ack), .query_blocked(query_blocked),
    .pos_x(pos_x), .pos_y(pos_y), .moved(moved), .bomb_req(bomb_req)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (moved === 1'b1) moved_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs;
    x_moving = 0; xdir = 0; y_moving = 0; ydir = 0;
    bomb = 0; alive = 1; query_ack = 0; query_blocked = 0;
  endtask

  task automatic apply_reset;
    reset = 1;
    #1;
    step(2);
    reset = 0;
  endtask

  task automatic wait_query(input string tag);
    int unsigned k = 0;
    while (query_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check(tag, {31'd0, query_req}, 32'd1);
  endtask

  task automatic do_move(input logic xm, input logic xd, input logic ym, input logic yd);
    x_moving = xm; xdir = xd; y_moving = ym; ydir = yd;
    wait_query("move_query");
    x_moving = 0; y_moving = 0;
    query_ack = 1; query_blocked = 0;
    step();
    query_ack = 0;
    step();
  endtask

  initial begin
    int unsigned cnt_q, cnt_b, m0;
    idle_inputs();

    // Free move, first-tick latency, latched target, bomb coincident with moved
    x_moving = 1; xdir = 1;
    apply_reset();
    check("rst_pos_x", {28'd0, pos_x}, 32'd1);
    check("rst_pos_y", {28'd0, pos_y}, 32'd1);
    check("rst_qreq", {31'd0, query_req}, 32'd0);
    check("rst_qx", {28'd0, query_x}, 32'd0);
    check("rst_bomb_req", {31'd0, bomb_req}, 32'd0);
    step(7);
    check("pre_tick_qreq", {31'd0, query_req}, 32'd0);
    step();
    check("tick_qreq", {31'd0, query_req}, 32'd1);
    check("free_qx", {28'd0, query_x}, 32'd2);
    check("free_qy", {28'd0, query_y}, 32'd1);
    xdir = 0;
    m0 = moved_cnt;
    step(2);
    check("hold_qx", {28'd0, query_x}, 32'd2);
    check("hold_qreq", {31'd0, query_req}, 32'd1);
    x_moving = 0;
    query_ack = 1; query_blocked = 0; bomb = 1;
    step();
    query_ack = 0;
    check("commit_moved", {31'd0, moved}, 32'd1);
    check("commit_bomb_req", {31'd0, bomb_req}, 32'd1);
    check("commit_pre_pos_x", {28'd0, pos_x}, 32'd1);
    step();
    bomb = 0;
    check("free_pos_x", {28'd0, pos_x}, 32'd2);
    check("free_pos_y", {28'd0, pos_y}, 32'd1);
    check("free_moved_off", {31'd0, moved}, 32'd0);
    check("free_qreq_off", {31'd0, query_req}, 32'd0);
    step(3);
    check("free_moved_once", moved_cnt - m0, 32'd1);

    // Blocked move
    idle_inputs();
    y_moving = 1; ydir = 0;
    apply_reset();
    step(8);
    check("blk_qreq", {31'd0, query_req}, 32'd1);
    check("blk_qx", {28'd0, query_x}, 32'd1);
    check("blk_qy", {28'd0, query_y}, 32'd0);
    m0 = moved_cnt;
    y_moving = 0;
    query_ack = 1; query_blocked = 1;
    step();
    query_ack = 0; query_blocked = 0;
    check("blk_qreq_off", {31'd0, query_req}, 32'd0);
    step(2);
    check("blk_pos_x", {28'd0, pos_x}, 32'd1);
    check("blk_pos_y", {28'd0, pos_y}, 32'd1);
    check("blk_no_moved", moved_cnt - m0, 32'd0);

    // Left edge and x-over-y priority
    idle_inputs();
    apply_reset();
    do_move(1, 0, 0, 0);
    repeat (4) do_move(0, 0, 1, 1);
    check("edge_pos_x", {28'd0, pos_x}, 32'd0);
    check("edge_pos_y", {28'd0, pos_y}, 32'd5);
    x_moving = 1; xdir = 0;
    cnt_q = 0;
    repeat (20) begin
      step();
      if (query_req === 1'b1) cnt_q++;
    end
    check("edge_no_query", cnt_q, 32'd0);
    xdir = 1; y_moving = 1; ydir = 1;
    wait_query("prio_qreq");
    check("prio_qx", {28'd0, query_x}, 32'd1);
    check("prio_qy", {28'd0, query_y}, 32'd5);
    x_moving = 0; y_moving = 0;
    query_ack = 1; query_blocked = 1;
    step();
    query_ack = 0; query_blocked = 0;

    // Bomb: hold, cooldown ignore, post-cooldown press
    idle_inputs();
    apply_reset();
    bomb = 1;
    step();
    check("bomb_latency", {31'd0, bomb_req}, 32'd1);
    cnt_b = 0;
    repeat (49) begin
      step();
      if (bomb_req === 1'b1) cnt_b++;
    end
    check("bomb_hold_single", cnt_b, 32'd0);
    bomb = 0;
    step(3);
    bomb = 1;
    step();
    check("bomb_p1", {31'd0, bomb_req}, 32'd1);
    bomb = 0;
    step(10);
    bomb = 1;
    step();
    check("bomb_cool_ignored", {31'd0, bomb_req}, 32'd0);
    bomb = 0;
    cnt_b = 0;
    repeat (14) begin
      step();
      if (bomb_req === 1'b1) cnt_b++;
    end
    check("bomb_not_deferred", cnt_b, 32'd0);
    bomb = 1;
    step();
    check("bomb_after_cool", {31'd0, bomb_req}, 32'd1);
    bomb = 0;

    // Reset mid-query
    idle_inputs();
    x_moving = 1; xdir = 1;
    apply_reset();
    step(8);
    check("rq_qreq", {31'd0, query_req}, 32'd1);
    reset = 1;
    #1;
    check("rq_async_drop", {31'd0, query_req}, 32'd0);
    m0 = moved_cnt;
    step();
    reset = 0;
    x_moving = 0;
    query_ack = 1;
    step();
    query_ack = 0;
    step(2);
    check("rq_pos_x", {28'd0, pos_x}, 32'd1);
    check("rq_pos_y", {28'd0, pos_y}, 32'd1);
    check("rq_qreq_off", {31'd0, query_req}, 32'd0);
    check("rq_no_moved", moved_cnt - m0, 32'd0);

    // Dead player
    idle_inputs();
    apply_reset();
    alive = 0; x_moving = 1; xdir = 1; y_moving = 1; ydir = 1; bomb = 1;
    cnt_q = 0; cnt_b = 0;
    repeat (40) begin
      step();
      if (query_req === 1'b1) cnt_q++;
      if (bomb_req === 1'b1) cnt_b++;
    end
    check("dead_no_query", cnt_q, 32'd0);
    check("dead_no_bomb", cnt_b, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/player_controller.md
PLAYER_CONTROLLER -- requirements
Module: player_controller

Interface
REQ-001 Parameter GRID_W, 15, number of tile columns; legal x is 0..GRID_W-1.
REQ-002 Parameter GRID_H, 11, number of tile rows; legal y is 0..GRID_H-1.
REQ-003 Parameter START_X, 1, tile x loaded on reset.
REQ-004 Parameter START_Y, 1, tile y loaded on reset.
REQ-005 Parameter STEP_CYCLES, 5000000, clock cycles per movement tick (minimum 4).
REQ-006 Parameter BOMB_COOLDOWN, 25000000, cycles after a bomb request during which further requests are suppressed.
REQ-007 clock  in  1  system clock; all state changes on the rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 x_moving  in  1  1 = player requests horizontal motion.
REQ-010 xdir  in  1  0 = left, 1 = right; meaningful only when x_moving=1.
REQ-011 y_moving  in  1  1 = player requests vertical motion.
REQ-012 ydir  in  1  0 = up, 1 = down; meaningful only when y_moving=1.
REQ-013 bomb  in  1  level; 1 = player holds the bomb key.
REQ-014 alive  in  1  0 = player dead; freezes motion and bomb requests.
REQ-015 query_req  out  1  level; map lookup pending for tile (query_x, query_y).
REQ-016 query_x, query_y  out  4 each  target tile of the pending lookup.
REQ-017 query_ack  in  1  one-cycle pulse; lookup result valid this cycle.
REQ-018 query_blocked  in  1  1 = target tile is a wall, crate or bomb; sampled only with query_ack.
REQ-019 pos_x, pos_y  out  4 each  current player tile.
REQ-020 moved  out  1  one-cycle pulse when pos_x/pos_y changes.
REQ-021 bomb_req  out  1  one-cycle pulse requesting a bomb at (pos_x, pos_y).

Function
REQ-022 FSM states: IDLE, QUERY, COMMIT.
- IDLE: step counter counts 0..STEP_CYCLES-1 and wraps; a wrap is a tick.
REQ-023 On a tick in IDLE with alive=1 and a movement request, compute the target tile and go to QUERY; otherwise remain in IDLE.
REQ-024 Target selection:
- x_moving has priority over y_moving when both are 1.
- x-1 for xdir=0, x+1 for xdir=1; y-1 for ydir=0, y+1 for ydir=1.
REQ-025 If the target lies outside 0..GRID_W-1 or 0..GRID_H-1, no query is issued; the tick is discarded and the FSM stays in IDLE.
REQ-026 QUERY:
- query_req=1 and query_x/query_y are held stable until query_ack.
- on query_ack with query_blocked=0, go to COMMIT.
- on query_ack with query_blocked=1, return to IDLE with position unchanged.
REQ-027 COMMIT, lasting one cycle:
- load pos_x/pos_y with the target.
- assert moved for that same cycle.
- return to IDLE.
REQ-028 The step counter keeps running during QUERY/COMMIT; ticks arriving outside IDLE are dropped, not queued.
REQ-029 Input changes during QUERY do not alter the latched target.
REQ-030 If alive falls during QUERY, wait for query_ack, then return to IDLE without committing.
REQ-031 bomb_req pulses one cycle on a 0->1 edge of bomb (registered edge detect) when alive=1 and the cooldown counter is 0.
- that pulse reloads the cooldown counter with BOMB_COOLDOWN-1.
- the counter decrements to 0 and saturates there.
REQ-032 Holding bomb high produces exactly one bomb_req.
REQ-033 An edge during cooldown is ignored, not deferred.
REQ-034 bomb_req and moved may assert in the same cycle.
- bomb_req then reports the pre-move position: pos_x/pos_y before the COMMIT update.
REQ-035 Latency: a bomb edge produces bomb_req exactly 1 cycle after the edge is sampled; query_ack unblocked produces moved 1 cycle later.

Reset
REQ-036 While reset=1, asynchronously:
- pos_x=START_X, pos_y=START_Y.
- FSM=IDLE, step counter=0, cooldown=0, edge register=0.
- query_req=0, query_x=0, query_y=0, moved=0, bomb_req=0.
REQ-037 Reset mid-QUERY abandons the lookup; query_req drops immediately, and a later query_ack is ignored.
REQ-038 After reset deasserts, the first tick occurs STEP_CYCLES cycles later.

Verification (STEP_CYCLES=8, BOMB_COOLDOWN=20)
REQ-039 Free move:
- stimulus: reset, x_moving=1, xdir=1; at the tick, ack with blocked=0 after 3 cycles.
- required: query (2,1); one cycle after the ack, pos=(2,1) and moved pulses once.
REQ-040 Blocked move:
- stimulus: y_moving=1, ydir=0, ack with blocked=1.
- required: query (1,0); pos stays (1,1); moved stays 0.
REQ-041 Edge and priority:
- stimulus A: pos=(0,5), x_moving=1, xdir=0.
- required A: no query_req at the tick.
- stimulus B: x_moving=1 and y_moving=1.
- required B: query on x only.
REQ-042 Bomb cooldown:
- stimulus: bomb held for 50 cycles, released, then pressed at cycle 10 and again at cycle 25 after the first pulse.
- required: one pulse at hold; 10-cycle press ignored; 25-cycle press pulses.
REQ-043 Reset mid-query:
- stimulus: assert reset while query_req=1, then send query_ack after release.
- required: pos=(1,1), query_req=0, no moved.
REQ-044 Dead player:
- stimulus: alive=0 with all requests active for 40 cycles.
- required: no query_req, no bomb_req.
